// File: rtl/ao_apb_initiator_pkg.sv
// ao_apb_initiator_pkg: shared types and constants for the always-on APB4 initiator.
//   state_t       : transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//   req_t         : request latched at acceptance (write, word-aligned addr, wdata, strb)
//   PPROT_DEFAULT : protection attributes driven on every transfer
//   word_align    : clears byte-offset bits so paddr[1:0] is always 0
package ao_apb_initiator_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    // addr is held at full 32-bit width; the top truncates it to its AW.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/ao_apb_initiator_wdog.sv
// ao_apb_initiator_wdog: ACCESS-phase wait counter that flags a stuck slave.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_start  : clears the count (asserted the cycle before ACCESS is entered)
//   i_tick   : one ACCESS cycle elapsed with pready low
//   o_expire : this tick brings the count to TIMEOUT
// Only instantiated when AO_APB_INITIATOR_TIMEOUT_EN is defined.
module ao_apb_initiator_wdog #(
    parameter int TOW     = 8,
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_tick,
    output logic o_expire
);

    logic [TOW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else if (i_start) r_cnt <= '0;
        else if (i_tick) r_cnt <= r_cnt + 1'b1;
    end

    // r_cnt holds the number of earlier stalled cycles, so the current tick
    // is the TIMEOUT-th one when r_cnt == TIMEOUT-1.
    assign o_expire = i_tick && (r_cnt == TOW'(TIMEOUT - 1));

endmodule

// File: rtl/ao_apb_initiator.sv
// ao_apb_initiator: APB4 requester for the always-on domain, one transfer outstanding.
//   i_pclk, i_resetn          : clock (rising edge), asynchronous active-low reset
//   i_req_* / o_req_ready     : request channel (write, addr, wdata, strb), valid/ready
//   o_rsp_* / i_rsp_ready     : registered response (rdata, err, timeout), valid/ready
//   o_psel ... o_pprot        : APB4 requester outputs, all registered
//   i_prdata, i_pready, i_pslverr : APB4 completer inputs
// Optional: define AO_APB_INITIATOR_TIMEOUT_EN to abort ACCESS after TIMEOUT
// stalled cycles; otherwise ACCESS waits indefinitely and o_rsp_timeout stays 0.
module ao_apb_initiator
    import ao_apb_initiator_pkg::*;
#(
    parameter int AW      = 12,
    parameter int TOW     = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          i_pclk,
    input  logic          i_resetn,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_write,
    input  logic [AW-1:0] i_req_addr,
    input  logic [31:0]   i_req_wdata,
    input  logic [3:0]    i_req_strb,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   o_rsp_rdata,
    output logic          o_rsp_err,
    output logic          o_rsp_timeout,
    output logic          o_psel,
    output logic          o_penable,
    output logic          o_pwrite,
    output logic [AW-1:0] o_paddr,
    output logic [31:0]   o_pwdata,
    output logic [3:0]    o_pstrb,
    output logic [2:0]    o_pprot,
    input  logic [31:0]   i_prdata,
    input  logic          i_pready,
    input  logic          i_pslverr
);

    if (TIMEOUT < 1 || TIMEOUT > 2**TOW - 1) begin : g_bad_cfg
        $error("ao_apb_initiator: TIMEOUT out of range for TOW");
    end

    state_t      r_state;
    req_t        r_req;
    logic        r_psel;
    logic        r_penable;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_rsp_timeout;
    logic        w_expire;

`ifdef AO_APB_INITIATOR_TIMEOUT_EN
    ao_apb_initiator_wdog #(
        .TOW     (TOW),
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_clk    (i_pclk),
        .i_rst_n  (i_resetn),
        .i_start  (r_state == SETUP),
        .i_tick   (r_state == ACCESS && !i_pready),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge i_pclk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state       <= IDLE;
            r_req         <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_req_valid) begin
                    // Reads carry no strobes on the bus.
                    r_req       <= '{i_req_write, word_align(32'(i_req_addr)), i_req_wdata,
                                     i_req_write ? i_req_strb : 4'h0};
                    r_req_ready <= 1'b0;
                    r_psel      <= 1'b1;
                    r_state     <= SETUP;
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                // pready has priority over an expiry in the same cycle; pslverr
                // is only looked at when pready is high.
                ACCESS: if (i_pready || w_expire) begin
                    r_psel        <= 1'b0;
                    r_penable     <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_rdata   <= (i_pready && !r_req.write) ? i_prdata : '0;
                    r_rsp_err     <= i_pready ? i_pslverr : 1'b1;
                    r_rsp_timeout <= !i_pready;
                    r_state       <= RESP;
                end
                RESP: if (i_rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_psel        = r_psel;
    assign o_penable     = r_penable;
    assign o_pwrite      = r_req.write;
    assign o_paddr       = AW'(r_req.addr);
    assign o_pwdata      = r_req.wdata;
    assign o_pstrb       = r_req.strb;
    assign o_pprot       = PPROT_DEFAULT;

endmodule
